// File: rtl/tdm_mux_8x1.sv
// Eight-channel round-robin TDM multiplexer: merges eight valid/ready lanes onto one
// registered output stream tagged with the 3-bit source channel index.
module tdm_mux_8x1 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_valid,
    input  logic [8*WIDTH-1:0] in_data,
    output logic [7:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [2:0]         out_sel,
    input  logic               out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           r_state;
    logic [2:0]       r_ptr;
    logic [WIDTH-1:0] r_data;
    logic [2:0]       r_sel;

    logic             w_any;
    logic             w_load;
    logic [2:0]       w_idx;
    logic [2:0]       w_winner;

    assign w_any  = |in_valid;
    assign w_load = ((r_state == EMPTY) || out_ready) && w_any;

    // Scan from the far end back toward r_ptr so the closest valid channel wins last.
    // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        w_idx    = r_ptr;
        w_winner = r_ptr;
        for (int k = 7; k >= 0; k--) begin
            w_idx = r_ptr + 3'(k);
            if (in_valid[w_idx]) begin
                w_winner = w_idx;
            end
        end
    end

    // Grants are suppressed during reset so no upstream word is consumed and lost.
    always_comb begin
        in_ready = '0;
        if (!rst && w_load) begin
            in_ready[w_winner] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_ptr   <= '0;
            r_data  <= '0;
            r_sel   <= '0;
        end else begin
            if (w_load) begin
                r_state <= FULL;
                r_data  <= in_data[w_winner*WIDTH +: WIDTH];
                r_sel   <= w_winner;
                r_ptr   <= w_winner + 3'd1;
            end else if (r_state == FULL && out_ready) begin
                // Drained with nothing to refill: data, tag and pointer keep their values.
                r_state <= EMPTY;
            end
        end
    end

    assign out_valid = (r_state == FULL);
    assign out_data  = r_data;
    assign out_sel   = r_sel;

endmodule

// File: doc/tdm_mux_8x1.md
# tdm_mux_8x1

Eight-channel round-robin time-division multiplexer. It merges eight valid/ready input channels onto one registered output stream. Each output word is tagged with the 3-bit index of its source channel, so the 1x8 demultiplexer at the far end of the link can route the word back to its lane. The block sits on the transmit side of the channel-tagged link, directly upstream of the demux stage.

## Interface
Parameters:
- WIDTH, 8, data bits per channel word

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  8  bit i set when channel i presents a word
- in_data  input  8*WIDTH  channel i word at bits [i*WIDTH +: WIDTH]
- in_ready  output  8  bit i set when channel i's word is accepted this cycle
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  held word
- out_sel  output  3  source channel index of held word
- out_ready  input  1  downstream accepts held word this cycle

## Operation
- State:
  - output register: out_valid, out_data, out_sel;
  - round-robin pointer ptr[2:0], the first channel to search.
- Control logic is two states, EMPTY (out_valid=0) and FULL (out_valid=1).
- Load condition: load = (!out_valid || out_ready) && (in_valid != 0).
- Winner selection:
  - Winner = first channel i in search order ptr, ptr+1, …, ptr+7 (mod 8) with in_valid[i]=1.
  - in_ready[i] = load && (i == winner); at most one bit is set.
  - in_ready is combinational from in_valid, ptr, out_valid and out_ready.
  - in_valid never depends on in_ready, so no loop exists.
- On a load edge:
  - out_data <= winner word; out_sel <= winner; out_valid <= 1;
  - ptr <= winner + 1 (mod 8, so 7 wraps to 0).
- Drain without refill: out_valid && out_ready && in_valid == 0 gives out_valid <= 0. out_data, out_sel and ptr keep their values.
- Stall: out_valid && !out_ready means out_data and out_sel are held stable, in_ready = 0, and ptr is unchanged.
- A channel may hold in_valid with unchanged in_data indefinitely. Its word is consumed only on the cycle in which its in_ready bit is set.
- Fairness: with all eight channels continuously valid and out_ready=1, the grant order is ptr, ptr+1, … with no channel repeated within 8 grants.
- The block does no width arithmetic beyond the 3-bit modulo-8 pointer increment.

## Timing
- Reset (rst=1, asynchronous):
  - out_valid=0, out_data=0, out_sel=0, ptr=0;
  - in_ready is forced to 0 while rst is high.
- Latency: a word accepted at edge N appears on out_data/out_sel with out_valid=1 after edge N, i.e. 1 cycle.
- Throughput: one word per cycle when out_ready is held high. Simultaneous drain and refill in the same cycle causes no bubble.
- Back-pressure takes effect in the same cycle: out_ready=0 while FULL forces in_ready=0 combinationally.
- Reset mid-operation:
  - the held word is dropped and not replayed;
  - ptr returns to 0;
  - the first load after rst deasserts searches from channel 0.

## Test plan
- Reset then single channel:
  - Stimulus: rst pulse, then in_valid=8'b0000_0100, ch2 word 8'hA5, out_ready=1.
  - Response: in_ready=8'b0000_0100 in that cycle; next cycle out_valid=1, out_data=8'hA5, out_sel=3'd2, ptr=3.
- All channels valid, out_ready=1, ch i word = 8'h10+i:
  - Response: out_sel sequence 0,1,2,…,7,0 on consecutive cycles with out_data tracking it.
  - Response: no idle cycle and no repeated channel within 8 grants.
- Wrap-around:
  - Stimulus: ptr brought to 7, then in_valid=8'b1000_0001.
  - Response: ch7 is granted first, then ch0; ptr goes 7 -> 0 -> 1.
- Stall:
  - Stimulus: FULL with out_sel=3, out_data=8'h33, then out_ready=0 for 4 cycles with in_valid=8'hFF.
  - Response: out_data/out_sel stay at 8'h33/3 and in_ready=0 throughout. After out_ready returns to 1, ch4 is granted next.
- Drain to empty:
  - Stimulus: FULL, out_ready=1, in_valid=0.
  - Response: out_valid falls next cycle, and out_data/out_sel keep their last values.
- Reset mid-stream:
  - Stimulus: rst asserted asynchronously between edges while FULL with out_sel=5.
  - Response: out_valid, out_data, out_sel and in_ready drop to 0 immediately, without waiting for an edge. After release, with in_valid=8'hFF, the first grant is ch0.
